// File: rtl/mc_main_ctrl_fsm.sv
// Main control FSM for the multicycle MIPS datapath: sequences each instruction and
// drives datapath enables, mux selects and ALUOp, with a timeout guard on memory waits.
module mc_main_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       mem_fault,
  output logic [3:0] state_o
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAddiu = 6'b001001;

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] TimeoutVal = CntW'(MEM_TIMEOUT);
  localparam logic            TimeoutEn  = (MEM_TIMEOUT != 0);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StRex    = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StIex    = 4'd10,
    StIwb    = 4'd11
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_q, wait_d;
  logic            mem_wait;
  logic            timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign mem_wait = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  // mem_ready in the same cycle takes priority over the timeout.
  assign timeout  = TimeoutEn && mem_wait && !mem_ready && (wait_q == TimeoutVal);
  assign state_o  = state_q;

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    mem_fault     = 1'b0;

    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end else if (timeout) begin
          mem_fault = 1'b1;
        end
      end
      StDecode: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b = 2'b11;
        case (opcode)
          OpRtype:         state_d = StRex;
          OpLw, OpSw:      state_d = StMemAdr;
          OpBeq, OpBne:    state_d = StBranch;
          OpJ:             state_d = StJump;
          OpAddi, OpAddiu: state_d = StIex;
          default: begin
            illegal_op = 1'b1;
            state_d    = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (timeout) begin
          mem_fault = 1'b1;
          state_d   = StFetch;
        end
      end
      StMemWb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          state_d = StFetch;
        end else if (timeout) begin
          mem_fault = 1'b1;
          state_d   = StFetch;
        end
      end
      StRex: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = StRwb;
      end
      StRwb: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_source     = 2'b01;
        pc_write_cond = 1'b1;
        branch_ne     = (opcode == OpBne);
        state_d       = StFetch;
      end
      StJump: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        state_d   = StFetch;
      end
      StIex: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = StIwb;
      end
      StIwb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // A timed-out fetch restarts with a fresh count even though the state is unchanged.
    if ((state_d != state_q) || timeout) begin
      wait_d = '0;
    end else if (mem_wait && !mem_ready && (wait_q != TimeoutVal)) begin
      wait_d = wait_q + CntW'(1);
    end else begin
      wait_d = wait_q;
    end

    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      illegal_op    = 1'b0;
      mem_fault     = 1'b0;
    end
  end

endmodule
